branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  ID-stage hazard controller sitting directly upstream of the branch forwarding mux select logic.
//  Decides when a beq/bnq in ID can resolve (operands forwarded from EX/MEM) or must stall.
//  Stalls when a load producer is not yet ready, and flushes IF/ID on a taken branch.
//  Also stalls ordinary load-use; keeps saturating stall/flush counters for perf debug.
// PARAMETERS
//  CNT_W   16  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    async active-high reset
//  IDRs         in   5    rs of instruction in ID
//  IDRt         in   5    rt of instruction in ID
//  beq          in   1    ID instruction is beq
//  bnq          in   1    ID instruction is bne
//  EXRd         in   5    destination reg of instruction in EX
//  EX_regwrite  in   1    EX instruction writes a register
//  EX_memread   in   1    EX instruction is a load
//  MEMRd        in   5    destination reg of instruction in MEM
//  MEM_memread  in   1    MEM instruction is a load
//  br_taken     in   1    ID comparator result (valid only when branch not stalled)
//  pc_write     out  1    PC enable; 0 = hold PC
//  ifid_write   out  1    IF/ID enable; 0 = hold IF/ID
//  idex_bubble  out  1    1 = zero ID/EX control bits (insert nop)
//  ifid_flush   out  1    1 = clear IF/ID (kill fetched instr)
//  stall_cnt    out  CNT_W  stall cycles since reset
//  flush_cnt    out  CNT_W  taken-branch flushes since reset
// BEHAVIOUR
//  Reset (async): state=RUN, stall_cnt=0, flush_cnt=0.
//   Outputs during reset: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
//  br = beq|bnq.
//  depEX  = EX_regwrite  & EXRd!=0  & (EXRd==IDRs | EXRd==IDRt).
//  depMEM = MEM_memread  & MEMRd!=0 & (MEMRd==IDRs | MEMRd==IDRt).
//  Reg 0 never creates a hazard.
//  FSM states: RUN, LD2 (2nd stall of branch-after-load), registered, one-hot-free 1-bit encoding ok.
//  In RUN, priority top-down:
//   a) br & depEX & EX_memread  -> stall now, next=LD2
//   b) br & depMEM              -> stall now, next=RUN
//   c) !br & depEX & EX_memread -> stall now (load-use), next=RUN
//   d) br & br_taken            -> ifid_flush=1, no stall, flush_cnt++, next=RUN
//   e) else                     -> pass, next=RUN
//  In LD2: stall unconditionally, next=RUN.
//   Load is now in MEM; it reaches WB next cycle and the register file write-through covers it.
//  ALU (non-load) producer in EX: no stall; resolved by EX->ID forwarding.
//  Stall = pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
//   stall_cnt++ every stall cycle.
//  br_taken is ignored in any stall cycle; flush only in case d.
//  Stall and flush are never asserted in the same cycle.
//  Counters saturate at all-ones (no wrap).
//  All outputs except the counters are combinational from state + inputs (0-cycle latency).
//  Counters update on the clk edge.
//  Async rst mid-stall (incl. LD2) returns to RUN immediately.
//   No residual stall after rst deasserts.
// STRUCTURE
//  Shared package/header:
//   - state encodings RUN/LD2
//   - REG_ZERO=5'd0
//   - control-bundle width constants shared with the ID/EX register.
//  One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt).
//   Instantiated twice (stall, flush).
//  Everything else is one always_comb/always block for next-state/outputs.
//  One async-reset flop block.
// TESTING
//  1. rst=1 then release, idle inputs.
//     -> pc_write=1, ifid_write=1, bubble=0, flush=0, counters=0.
//  2. beq IDRs=3; EX load EXRd=3.
//     -> stall 2 cycles (cycle2 in LD2, MEM load Rd=3), resume cycle 3; stall_cnt=2.
//  3. bnq IDRt=5; EX ALU EXRd=5 EX_regwrite=1, br_taken=1.
//     -> no stall, ifid_flush=1 for 1 cycle, flush_cnt=1.
//  4. add IDRs=7; EX load EXRd=7.
//     -> exactly 1 stall cycle. Same with EXRd=0, IDRs=0 -> no stall.
//  5. beq; MEM load MEMRd=4=IDRs, br_taken=1.
//     -> 1 stall, flush suppressed that cycle; next cycle flush=1.
//  6. rst asserted during LD2.
//     -> outputs return to pass values immediately, state RUN; counters 0.
//     Also preload counters to all-ones -> they hold.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch/load hazard controller.
// Control-bundle widths match the ID/EX pipeline register.
package branch_hazard_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   localparam int unsigned IDEX_EX_CTRL_W = 4;
   localparam int unsigned IDEX_M_CTRL_W  = 2;
   localparam int unsigned IDEX_WB_CTRL_W = 2;
   localparam int unsigned IDEX_CTRL_W    = IDEX_EX_CTRL_W + IDEX_M_CTRL_W + IDEX_WB_CTRL_W;

   typedef enum logic {
      StRun = 1'b0,
      StLd2 = 1'b1
   } hz_state_e;

   // Producer rd matches a source of the ID instruction; r0 never counts.
   function automatic logic reg_dep(input logic                  valid,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rt);
      return valid && (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM register info in, pipeline enables out.
interface branch_hazard_ctrl_if;
   import branch_hazard_ctrl_pkg::*;

   logic [REG_ADDR_W-1:0] IDRs;
   logic [REG_ADDR_W-1:0] IDRt;
   logic                  beq;
   logic                  bnq;
   logic [REG_ADDR_W-1:0] EXRd;
   logic                  EX_regwrite;
   logic                  EX_memread;
   logic [REG_ADDR_W-1:0] MEMRd;
   logic                  MEM_memread;
   logic                  br_taken;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  idex_bubble;
   logic                  ifid_flush;

   modport master (
      output IDRs, IDRt, beq, bnq, EXRd, EX_regwrite, EX_memread, MEMRd, MEM_memread, br_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush
   );

   modport slave (
      input  IDRs, IDRt, beq, bnq, EXRd, EX_regwrite, EX_memread, MEMRd, MEM_memread, br_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush
   );

endinterface

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-high reset; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage hazard controller: stalls branches/loads on unready producers,
// flushes IF/ID on a taken branch, and counts stalls and flushes.
module branch_hazard_ctrl
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_hazard_ctrl_if.slave  hz,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   hz_state_e state_q, state_d;
   logic      br, dep_ex, dep_mem, ex_load;
   logic      stall, flush;

   assign br      = hz.beq | hz.bnq;
   assign dep_ex  = reg_dep(hz.EX_regwrite, hz.EXRd, hz.IDRs, hz.IDRt);
   assign dep_mem = reg_dep(hz.MEM_memread, hz.MEMRd, hz.IDRs, hz.IDRt);
   assign ex_load = dep_ex & hz.EX_memread;

   always_comb begin
      state_d = StRun;
      stall   = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         StRun: begin
            if (br && ex_load) begin
               stall   = 1'b1;
               state_d = StLd2;
            end else if (br && dep_mem) begin
               stall = 1'b1;
            end else if (!br && ex_load) begin
               stall = 1'b1;
            end else if (br && hz.br_taken) begin
               flush = 1'b1;
            end
         end
         // Load now in MEM; one more bubble lets register-file write-through cover it.
         StLd2: begin
            stall = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase
      // Reset forces pass values regardless of the hazard inputs.
      if (rst) begin
         stall = 1'b0;
         flush = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   assign hz.pc_write    = ~stall;
   assign hz.ifid_write  = ~stall;
   assign hz.idex_bubble = stall;
   assign hz.ifid_flush  = flush;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .cnt (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; a second 2-bit-counter instance checks saturation.
module tb_branch_hazard_ctrl;

   localparam logic [3:0] PASS  = 4'b1100; // {pc_write, ifid_write, idex_bubble, ifid_flush}
   localparam logic [3:0] STALL = 4'b0010;
   localparam logic [3:0] FLUSH = 4'b1101;

   logic        clk;
   logic        rst;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  stall_cnt2, flush_cnt2;
   int          n_assert;
   int          n_fail;

   branch_hazard_ctrl_if hz ();
   branch_hazard_ctrl_if hz2 ();

   branch_hazard_ctrl #(
      .CNT_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hz        (hz),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   branch_hazard_ctrl #(
      .CNT_W (2)
   ) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .hz        (hz2),
      .stall_cnt (stall_cnt2),
      .flush_cnt (flush_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, hz.pc_write, hz.ifid_write, hz.idex_bubble, hz.ifid_flush}, {28'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.IDRs = 5'd0; hz.IDRt = 5'd0; hz.beq = 1'b0; hz.bnq = 1'b0;
      hz.EXRd = 5'd0; hz.EX_regwrite = 1'b0; hz.EX_memread = 1'b0;
      hz.MEMRd = 5'd0; hz.MEM_memread = 1'b0; hz.br_taken = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle();
      hz2.IDRs = 5'd0; hz2.IDRt = 5'd0; hz2.beq = 1'b0; hz2.bnq = 1'b0;
      hz2.EXRd = 5'd0; hz2.EX_regwrite = 1'b0; hz2.EX_memread = 1'b0;
      hz2.MEMRd = 5'd0; hz2.MEM_memread = 1'b0; hz2.br_taken = 1'b0;

      // 1: reset, including hazard inputs present while rst is high
      #2;
      hz.beq = 1'b1; hz.IDRs = 5'd3; hz.EXRd = 5'd3; hz.EX_regwrite = 1'b1; hz.EX_memread = 1'b1;
      #1 chk_ctl("rst_hazard_masked", PASS);
      idle();
      tick(); tick();
      rst = 1'b0;
      #1 chk_ctl("rst_release_ctl", PASS);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

      // 2: beq after load -> two stalls, br_taken ignored
      tick();
      hz.beq = 1'b1; hz.IDRs = 5'd3; hz.br_taken = 1'b1;
      hz.EXRd = 5'd3; hz.EX_regwrite = 1'b1; hz.EX_memread = 1'b1;
      #1 chk_ctl("brld_cyc1", STALL);
      tick();
      hz.EXRd = 5'd0; hz.EX_regwrite = 1'b0; hz.EX_memread = 1'b0;
      hz.MEMRd = 5'd3; hz.MEM_memread = 1'b1;
      #1 chk_ctl("brld_cyc2_ld2", STALL);
      chk("brld_stall_cnt1", {16'd0, stall_cnt}, 32'd1);
      tick();
      hz.MEMRd = 5'd0; hz.MEM_memread = 1'b0; hz.br_taken = 1'b0;
      #1 chk_ctl("brld_cyc3_resume", PASS);
      chk("brld_stall_cnt2", {16'd0, stall_cnt}, 32'd2);
      chk("brld_no_flush", {16'd0, flush_cnt}, 32'd0);

      // 3: bnq with ALU producer in EX, taken -> flush, no stall
      tick();
      idle();
      hz.bnq = 1'b1; hz.IDRt = 5'd5; hz.EXRd = 5'd5; hz.EX_regwrite = 1'b1; hz.br_taken = 1'b1;
      #1 chk_ctl("bnq_alu_taken", FLUSH);
      tick();
      idle();
      #1 chk_ctl("bnq_after", PASS);
      chk("bnq_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      chk("bnq_stall_cnt", {16'd0, stall_cnt}, 32'd2);

      // 4: load-use -> exactly one stall; r0 never hazards
      hz.IDRs = 5'd7; hz.EXRd = 5'd7; hz.EX_regwrite = 1'b1; hz.EX_memread = 1'b1;
      #1 chk_ctl("lduse_stall", STALL);
      tick();
      hz.EXRd = 5'd0; hz.EX_regwrite = 1'b0; hz.EX_memread = 1'b0;
      hz.MEMRd = 5'd7; hz.MEM_memread = 1'b1;
      #1 chk_ctl("lduse_one_only", PASS);
      chk("lduse_stall_cnt", {16'd0, stall_cnt}, 32'd3);
      idle();
      hz.EX_regwrite = 1'b1; hz.EX_memread = 1'b1;
      #1 chk_ctl("r0_no_stall", PASS);
      idle();
      hz.beq = 1'b1; hz.IDRs = 5'd6; hz.EXRd = 5'd6; hz.EX_regwrite = 1'b1;
      #1 chk_ctl("br_alu_not_taken", PASS);
      idle();
      hz.beq = 1'b1; hz.IDRt = 5'd0; hz.MEMRd = 5'd0; hz.MEM_memread = 1'b1;
      #1 chk_ctl("br_mem_r0", PASS);
      tick();
      chk("r0_stall_cnt", {16'd0, stall_cnt}, 32'd3);

      // 5: branch on MEM load, taken -> stall (flush suppressed), then flush
      idle();
      hz.beq = 1'b1; hz.IDRs = 5'd4; hz.MEMRd = 5'd4; hz.MEM_memread = 1'b1; hz.br_taken = 1'b1;
      #1 chk_ctl("brmem_stall", STALL);
      tick();
      hz.MEM_memread = 1'b0; hz.MEMRd = 5'd0;
      #1 chk_ctl("brmem_then_flush", FLUSH);
      chk("brmem_stall_cnt", {16'd0, stall_cnt}, 32'd4);
      chk("brmem_flush_cnt0", {16'd0, flush_cnt}, 32'd1);
      tick();
      idle();
      chk("brmem_flush_cnt1", {16'd0, flush_cnt}, 32'd2);

      // 6: async reset during LD2
      hz.beq = 1'b1; hz.IDRs = 5'd9; hz.EXRd = 5'd9; hz.EX_regwrite = 1'b1; hz.EX_memread = 1'b1;
      tick();
      idle();
      #1 chk_ctl("ld2_before_rst", STALL);
      chk("ld2_stall_cnt", {16'd0, stall_cnt}, 32'd5);
      rst = 1'b1;
      #1 chk_ctl("rst_in_ld2", PASS);
      chk("rst_ld2_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_ld2_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      rst = 1'b0;
      #1 chk_ctl("rst_ld2_release", PASS);
      tick();
      chk_ctl("rst_ld2_no_residual", PASS);
      chk("rst_ld2_cnt_hold", {16'd0, stall_cnt}, 32'd0);

      // Saturation on the 2-bit instance
      hz2.IDRs = 5'd1; hz2.EXRd = 5'd1; hz2.EX_regwrite = 1'b1; hz2.EX_memread = 1'b1;
      tick(); tick(); tick();
      chk("sat_stall_reach", {30'd0, stall_cnt2}, 32'd3);
      tick(); tick();
      chk("sat_stall_hold", {30'd0, stall_cnt2}, 32'd3);
      hz2.IDRs = 5'd0; hz2.EXRd = 5'd0; hz2.EX_regwrite = 1'b0; hz2.EX_memread = 1'b0;
      hz2.bnq = 1'b1; hz2.br_taken = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("sat_flush_hold", {30'd0, flush_cnt2}, 32'd3);
      chk("sat_stall_final", {30'd0, stall_cnt2}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
